// File: rtl/disp_scroll_pkg.sv
// -----------------------------------------------------------------------------
// disp_scroll_pkg
// Shared types and constants for the seven-segment scroll controller.
//   scroll_state_t : controller state (IDLE / RUN)
//   SEG_BLANK      : segment pattern with every segment off (segments are
//                    active-low, so all ones)
// -----------------------------------------------------------------------------
package disp_scroll_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } scroll_state_t;

   localparam logic [7:0] SEG_BLANK = 8'hff;

endpackage

// File: rtl/scroll_tick_gen.sv
// -----------------------------------------------------------------------------
// scroll_tick_gen
// Scroll-rate divider. Counts 0..TICK_DIV-1 while enabled and flags the
// cycle on which the count wraps; the counter holds while disabled.
//
// Parameters
//   TICK_DIV : clock cycles per tick (>= 2)
// Ports
//   clk   in  : system clock
//   reset in  : synchronous active-high reset, count returns to 0
//   en    in  : count enable (running and not paused)
//   clr   in  : return count to 0 (restart/stop/clear accepted)
//   tick  out : high for the single cycle whose rising edge wraps the count
// -----------------------------------------------------------------------------
module scroll_tick_gen #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // A clear in the same cycle as the wrap wins: no tick is reported.
   always_comb begin
      tick  = en && !clr && (cnt_q == CNT_MAX);
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = tick ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/disp_scroll_ctrl.sv
// -----------------------------------------------------------------------------
// disp_scroll_ctrl
// Scroll controller for the four-digit multiplexed seven-segment display.
// Stores up to DEPTH segment patterns and presents a four-digit window onto
// the virtual sequence {buf[0..len-1], BLANK x4}, stepping the window one
// position left every TICK_DIV cycles while running.
//
// Optional feature macro: DISP_SCROLL_PAUSE_EN adds the `pause` input, which
// freezes the scroll counter and position while in RUN.
//
// Parameters
//   DEPTH    : message buffer entries (>= 1)
//   TICK_DIV : clock cycles per scroll step (>= 2)
//   BLANK    : all-segments-off pattern
// Ports
//   clk              in  : system clock
//   reset            in  : synchronous active-high reset
//   clr              in  : empty the buffer, go IDLE
//   wr_en / wr_data  in  : append a pattern (IDLE only, dropped when full)
//   start            in  : begin / restart scrolling (needs len > 0)
//   stop             in  : end scrolling, go IDLE
//   pause            in  : freeze scroll (DISP_SCROLL_PAUSE_EN only)
//   in3..in0         out : registered window, in3 is the leftmost digit
//   len              out : stored entry count
//   full             out : len == DEPTH
//   busy             out : state is RUN
// -----------------------------------------------------------------------------
module disp_scroll_ctrl
   import disp_scroll_pkg::*;
#(
   parameter int         DEPTH    = 16,
   parameter int         TICK_DIV = 50_000_000,
   parameter logic [7:0] BLANK    = SEG_BLANK
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       clr,
   input  logic                       wr_en,
   input  logic [7:0]                 wr_data,
   input  logic                       start,
   input  logic                       stop,
`ifdef DISP_SCROLL_PAUSE_EN
   input  logic                       pause,
`endif
   output logic [7:0]                 in3,
   output logic [7:0]                 in2,
   output logic [7:0]                 in1,
   output logic [7:0]                 in0,
   output logic [$clog2(DEPTH+1)-1:0] len,
   output logic                       full,
   output logic                       busy
);

   localparam int LW = $clog2(DEPTH + 1);   // len width
   localparam int PW = $clog2(DEPTH + 4);   // pos width
   localparam int IW = PW + 1;              // room for pos+3 and len+4

   scroll_state_t state_q, state_d;
   logic [LW-1:0] len_q, len_d;
   logic [PW-1:0] pos_q, pos_d;
   logic [7:0]    buf_q [DEPTH];
   logic [7:0]    win_q [4];
   logic [7:0]    win_d [4];

   logic          pause_w;
   logic          full_w;
   logic          stop_act;
   logic          start_act;
   logic          wr_act;
   logic          tick_w;
   logic          tg_en;
   logic          tg_clr;
   logic [IW-1:0] period_w;
   logic [IW-1:0] len_ext;
   logic [IW-1:0] pos_inc;
   logic [PW-1:0] pos_nxt;
   logic [IW-1:0] idx_w [4];

`ifdef DISP_SCROLL_PAUSE_EN
   assign pause_w = pause;
`else
   assign pause_w = 1'b0;
`endif

   assign full_w = (len_q == LW'(DEPTH));

   // Control decode, priority clr > stop > start > wr_en/tick. A start with
   // an empty buffer in IDLE is not accepted and so does not restart timing.
   always_comb begin
      stop_act  = !clr && stop;
      start_act = !clr && !stop && start && ((state_q == RUN) || (len_q != '0));
      wr_act    = !clr && !stop && !start && wr_en && (state_q == IDLE) && !full_w;
   end

   assign tg_en  = (state_q == RUN) && !pause_w;
   assign tg_clr = clr || stop_act || start_act;

   scroll_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk   (clk),
      .reset (reset),
      .en    (tg_en),
      .clr   (tg_clr),
      .tick  (tick_w)
   );

   // Wrap uses the period len+4 at full width: one compare, no divider.
   always_comb begin
      len_ext  = IW'(len_q);
      period_w = len_ext + IW'(4);
      pos_inc  = {1'b0, pos_q} + IW'(1);
      pos_nxt  = (pos_inc == period_w) ? '0 : pos_inc[PW-1:0];
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      if (clr || stop) begin
         state_d = IDLE;
      end else if (start_act) begin
         state_d = RUN;
      end
   end

   // FSM: outputs
   always_comb begin
      busy = (state_q == RUN);
   end

   // Length and scroll position
   always_comb begin
      len_d = len_q;
      pos_d = pos_q;
      if (clr) begin
         len_d = '0;
         pos_d = '0;
      end else if (stop_act || start_act) begin
         pos_d = '0;
      end else if (wr_act) begin
         len_d = len_q + LW'(1);
      end else if (tick_w) begin
         pos_d = pos_nxt;
      end
   end

   // Window: each digit's index is pos+k folded once into 0..len+3
   // (pos < len+4 and k <= 3 < len+4, so a single subtract suffices);
   // indices at or beyond len fall in the trailing blank run.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         idx_w[k] = {1'b0, pos_q} + IW'(k);
         if (idx_w[k] >= period_w) begin
            idx_w[k] = idx_w[k] - period_w;
         end
         win_d[k] = BLANK;
         if (idx_w[k] < len_ext) begin
            for (int j = 0; j < DEPTH; j++) begin
               if (idx_w[k] == IW'(j)) begin
                  win_d[k] = buf_q[j];
               end
            end
         end
      end
   end

   // State registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         len_q   <= '0;
         pos_q   <= '0;
         for (int k = 0; k < 4; k++) begin
            win_q[k] <= BLANK;
         end
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         pos_q   <= pos_d;
         for (int k = 0; k < 4; k++) begin
            win_q[k] <= win_d[k];
         end
      end
   end

   // Message buffer: entries beyond len are never shown, so no reset needed.
   always_ff @(posedge clk) begin
      for (int j = 0; j < DEPTH; j++) begin
         if (wr_act && (len_q == LW'(j))) begin
            buf_q[j] <= wr_data;
         end
      end
   end

   assign in3  = win_q[0];
   assign in2  = win_q[1];
   assign in1  = win_q[2];
   assign in0  = win_q[3];
   assign len  = len_q;
   assign full = full_w;

endmodule
